// File: rtl/axi_txn_limiter_pkg.sv
// AXI4 channel and bundle types used by the transaction limiter and its bench.
// Widths are fixed here; instantiate with other struct types through the type parameters.
package axi_txn_limiter_pkg;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned UserW = 1;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [5:0]       atop;
        logic [UserW-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [UserW-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

endpackage

// File: rtl/axi_txn_limiter_counter.sv
// Outstanding-transaction counter for one address channel: gates new requests
// at the limit and keeps an already-presented request alive until its handshake.
module axi_txn_counter #(
    parameter int unsigned MaxTxns = 8,
    localparam int unsigned CntW = $clog2(MaxTxns + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            req_valid,
    input  logic            mst_ready,
    input  logic            dec,
    output logic            allow,
    output logic            lock,
    output logic [CntW-1:0] cnt
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

    logic [CntW-1:0] cnt_reg, cnt_next;
    logic            lock_reg, lock_next;
    logic            fwd_valid;
    logic            hs;

    // Allow depends only on registered state, so a same-cycle decrement never
    // opens the gate combinationally.
    assign allow     = lock_reg | (run & (cnt_reg < MaxCnt));
    assign fwd_valid = req_valid & allow;
    assign hs        = fwd_valid & mst_ready;
    assign lock      = lock_reg;
    assign cnt       = cnt_reg;

    always_comb begin
        lock_next = lock_reg;
        if (hs) begin
            lock_next = 1'b0;
        end else if (fwd_valid) begin
            lock_next = 1'b1;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (hs && !dec) begin
            cnt_next = cnt_reg + CntW'(1);
        end else if (!hs && dec && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            lock_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            lock_reg <= lock_next;
        end
    end

    // A response without any outstanding transaction is a protocol error upstream.
    assert property (@(posedge clk) disable iff (!rst_n) !(dec && !hs && (cnt_reg == '0)));

endmodule

// File: rtl/axi_txn_limiter.sv
// Caps outstanding AXI4 read/write transactions and drains the port on isolate request.
// Data and response channels pass straight through; only AW/AR handshakes are gated.
module axi_txn_limiter
    import axi_txn_limiter_pkg::*;
#(
    parameter int unsigned MaxReadTxns  = 8,
    parameter int unsigned MaxWriteTxns = 8,
    parameter type         req_t        = axi_req_t,
    parameter type         resp_t       = axi_resp_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  isolate_i,
    output logic                                  isolated_o,
    input  req_t                                  slv_req_i,
    output resp_t                                 slv_resp_o,
    output req_t                                  mst_req_o,
    input  resp_t                                 mst_resp_i,
    output logic [$clog2(MaxReadTxns + 1)-1:0]    rd_cnt_o,
    output logic [$clog2(MaxWriteTxns + 1)-1:0]   wr_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        ISOLATED
    } state_e;

    state_e state_reg, state_next;
    logic   run;
    logic   aw_allow, ar_allow;
    logic   aw_lock, ar_lock;
    logic   b_done, r_done;

    assign run    = (state_reg == RUN);
    assign b_done = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_done = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    axi_txn_counter #(
        .MaxTxns (MaxWriteTxns)
    ) u_wr_counter (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .run       (run),
        .req_valid (slv_req_i.aw_valid),
        .mst_ready (mst_resp_i.aw_ready),
        .dec       (b_done),
        .allow     (aw_allow),
        .lock      (aw_lock),
        .cnt       (wr_cnt_o)
    );

    axi_txn_counter #(
        .MaxTxns (MaxReadTxns)
    ) u_rd_counter (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .run       (run),
        .req_valid (slv_req_i.ar_valid),
        .mst_ready (mst_resp_i.ar_ready),
        .dec       (r_done),
        .allow     (ar_allow),
        .lock      (ar_lock),
        .cnt       (rd_cnt_o)
    );

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_allow;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_allow;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
    end

    // Isolation completes only once every counted transaction and any held
    // address request have been retired.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (isolate_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!isolate_i) begin
                    state_next = RUN;
                end else if ((rd_cnt_o == '0) && (wr_cnt_o == '0) && !aw_lock && !ar_lock) begin
                    state_next = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_i) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    assign isolated_o = (state_reg == ISOLATED);

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Directed and randomized checks of the AXI transaction limiter with
// MaxReadTxns=3 and MaxWriteTxns=2.
module tb_axi_txn_limiter;
    import axi_txn_limiter_pkg::*;

    localparam int MaxRd = 3;
    localparam int MaxWr = 2;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      isolate = 1'b0;
    logic      isolated;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    logic [1:0] rd_cnt, wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_txn_limiter #(
        .MaxReadTxns  (MaxRd),
        .MaxWriteTxns (MaxWr),
        .req_t        (axi_req_t),
        .resp_t       (axi_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .isolate_i  (isolate),
        .isolated_o (isolated),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .rd_cnt_o   (rd_cnt),
        .wr_cnt_o   (wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        slv_req = '0;
        mst_resp = '0;
        rst_n = 1'b0;
        slv_req.aw_valid = 1'b1;
        #2;
        checks++; if (rd_cnt !== 2'd0) begin errors++; $display("FAIL reset_rd_cnt: got %0d expected 0", rd_cnt); end
        checks++; if (wr_cnt !== 2'd0) begin errors++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
        checks++; if (isolated !== 1'b0) begin errors++; $display("FAIL reset_isolated: got %b expected 0", isolated); end
        checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL reset_aw_fwd: got %b expected 1", mst_req.aw_valid); end
        slv_req.aw_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        slv_req.w_valid = 1'b1;
        slv_req.w.data = 32'hDEADBEEF;
        slv_req.w.last = 1'b1;
        mst_resp.w_ready = 1'b1;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data = 32'h12345678;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp = 2'b10;
        #1;
        checks++; if (mst_req.w_valid !== 1'b1 || mst_req.w.data !== 32'hDEADBEEF || mst_req.w.last !== 1'b1) begin errors++; $display("FAIL pass_w: got v=%b d=%h expected v=1 d=deadbeef", mst_req.w_valid, mst_req.w.data); end
        checks++; if (slv_resp.w_ready !== 1'b1) begin errors++; $display("FAIL pass_wready: got %b expected 1", slv_resp.w_ready); end
        checks++; if (slv_resp.r_valid !== 1'b1 || slv_resp.r.data !== 32'h12345678) begin errors++; $display("FAIL pass_r: got v=%b d=%h expected v=1 d=12345678", slv_resp.r_valid, slv_resp.r.data); end
        checks++; if (slv_resp.b_valid !== 1'b1 || slv_resp.b.resp !== 2'b10) begin errors++; $display("FAIL pass_b: got v=%b resp=%b expected v=1 resp=10", slv_resp.b_valid, slv_resp.b.resp); end
        slv_req = '0;
        mst_resp = '0;
        tick();
        $display("test_passthrough done");
    endtask

    task automatic test_aw_limit();
        slv_req.aw_valid = 1'b1;
        mst_resp.aw_ready = 1'b1;
        #1;
        checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL awlim_first_fwd: got %b expected 1", mst_req.aw_valid); end
        tick();
        checks++; if (wr_cnt !== 2'd1) begin errors++; $display("FAIL awlim_cnt1: got %0d expected 1", wr_cnt); end
        tick();
        checks++; if (wr_cnt !== 2'd2) begin errors++; $display("FAIL awlim_cnt2: got %0d expected 2", wr_cnt); end
        checks++; if (mst_req.aw_valid !== 1'b0 || slv_resp.aw_ready !== 1'b0) begin errors++; $display("FAIL awlim_stall: got v=%b r=%b expected 0 0", mst_req.aw_valid, slv_resp.aw_ready); end
        tick();
        checks++; if (wr_cnt !== 2'd2 || mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL awlim_hold: got cnt=%0d v=%b expected 2 0", wr_cnt, mst_req.aw_valid); end
        mst_resp.b_valid = 1'b1;
        slv_req.b_ready = 1'b1;
        #1;
        checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL awlim_no_comb_b: got %b expected 0", mst_req.aw_valid); end
        tick();
        mst_resp.b_valid = 1'b0;
        checks++; if (wr_cnt !== 2'd1) begin errors++; $display("FAIL awlim_after_b: got %0d expected 1", wr_cnt); end
        #1;
        checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL awlim_third_fwd: got %b expected 1", mst_req.aw_valid); end
        tick();
        slv_req.aw_valid = 1'b0;
        checks++; if (wr_cnt !== 2'd2) begin errors++; $display("FAIL awlim_cnt_back2: got %0d expected 2", wr_cnt); end
        mst_resp.b_valid = 1'b1;
        tick();
        tick();
        mst_resp.b_valid = 1'b0;
        checks++; if (wr_cnt !== 2'd0) begin errors++; $display("FAIL awlim_drained: got %0d expected 0", wr_cnt); end
        slv_req = '0;
        mst_resp = '0;
        $display("test_aw_limit done");
    endtask

    task automatic test_ar_simul();
        slv_req.ar_valid = 1'b1;
        mst_resp.ar_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (rd_cnt !== 2'd3) begin errors++; $display("FAIL ar_cnt_max: got %0d expected 3", rd_cnt); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last = 1'b1;
        slv_req.r_ready = 1'b1;
        #1;
        checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL ar_max_blocked: got %b expected 0", mst_req.ar_valid); end
        tick();
        checks++; if (rd_cnt !== 2'd2) begin errors++; $display("FAIL ar_max_rlast: got %0d expected 2", rd_cnt); end
        checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL ar_refwd: got %b expected 1", mst_req.ar_valid); end
        tick();
        checks++; if (rd_cnt !== 2'd2) begin errors++; $display("FAIL ar_simul_unchanged: got %0d expected 2", rd_cnt); end
        slv_req.ar_valid = 1'b0;
        mst_resp.r.last = 1'b0;
        tick();
        checks++; if (rd_cnt !== 2'd2) begin errors++; $display("FAIL ar_nonlast_nodec: got %0d expected 2", rd_cnt); end
        mst_resp.r.last = 1'b1;
        tick();
        tick();
        mst_resp.r_valid = 1'b0;
        checks++; if (rd_cnt !== 2'd0) begin errors++; $display("FAIL ar_drained: got %0d expected 0", rd_cnt); end
        slv_req = '0;
        mst_resp = '0;
        $display("test_ar_simul done");
    endtask

    task automatic test_isolate_aw();
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id = 4'd5;
        #1;
        checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL iso_aw_fwd: got %b expected 1", mst_req.aw_valid); end
        tick();
        isolate = 1'b1;
        tick();
        checks++; if (mst_req.aw_valid !== 1'b1 || mst_req.aw.id !== 4'd5) begin errors++; $display("FAIL iso_aw_held: got v=%b id=%0d expected 1 5", mst_req.aw_valid, mst_req.aw.id); end
        tick();
        checks++; if (mst_req.aw_valid !== 1'b1 || isolated !== 1'b0) begin errors++; $display("FAIL iso_aw_held2: got v=%b iso=%b expected 1 0", mst_req.aw_valid, isolated); end
        mst_resp.aw_ready = 1'b1;
        tick();
        checks++; if (wr_cnt !== 2'd1) begin errors++; $display("FAIL iso_aw_hs: got %0d expected 1", wr_cnt); end
        checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL iso_no_new_aw: got %b expected 0", mst_req.aw_valid); end
        slv_req.aw_valid = 1'b0;
        mst_resp.aw_ready = 1'b0;
        mst_resp.b_valid = 1'b1;
        slv_req.b_ready = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        checks++; if (wr_cnt !== 2'd0 || isolated !== 1'b0) begin errors++; $display("FAIL iso_after_b: got cnt=%0d iso=%b expected 0 0", wr_cnt, isolated); end
        tick();
        checks++; if (isolated !== 1'b1) begin errors++; $display("FAIL iso_reached: got %b expected 1", isolated); end
        isolate = 1'b0;
        tick();
        checks++; if (isolated !== 1'b0) begin errors++; $display("FAIL iso_release: got %b expected 0", isolated); end
        slv_req = '0;
        mst_resp = '0;
        $display("test_isolate_aw done");
    endtask

    task automatic test_isolate_reads();
        int beats_ok = 0;
        slv_req.ar_valid = 1'b1;
        slv_req.ar.len = 8'd3;
        mst_resp.ar_ready = 1'b1;
        tick();
        tick();
        tick();
        slv_req.ar_valid = 1'b0;
        checks++; if (rd_cnt !== 2'd3) begin errors++; $display("FAIL isord_cnt3: got %0d expected 3", rd_cnt); end
        isolate = 1'b1;
        tick();
        slv_req.ar_valid = 1'b1;
        #1;
        checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL isord_ar_blocked: got %b expected 0", mst_req.ar_valid); end
        slv_req.ar_valid = 1'b0;
        slv_req.r_ready = 1'b1;
        mst_resp.r_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mst_resp.r.last = ((i % 4) == 3);
            mst_resp.r.data = 32'(i) + 32'h100;
            #1;
            if (slv_resp.r_valid === 1'b1 && slv_resp.r.data === 32'(i) + 32'h100) beats_ok++;
            tick();
        end
        mst_resp.r_valid = 1'b0;
        checks++; if (beats_ok !== 12) begin errors++; $display("FAIL isord_beats: got %0d expected 12", beats_ok); end
        checks++; if (rd_cnt !== 2'd0 || isolated !== 1'b0) begin errors++; $display("FAIL isord_cnt0: got cnt=%0d iso=%b expected 0 0", rd_cnt, isolated); end
        tick();
        checks++; if (isolated !== 1'b1) begin errors++; $display("FAIL isord_isolated: got %b expected 1", isolated); end
        isolate = 1'b0;
        tick();
        slv_req = '0;
        mst_resp = '0;
        $display("test_isolate_reads done");
    endtask

    task automatic test_async_reset();
        slv_req.aw_valid = 1'b1;
        slv_req.ar_valid = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        tick();
        tick();
        tick();
        slv_req = '0;
        mst_resp = '0;
        checks++; if (rd_cnt !== 2'd3 || wr_cnt !== 2'd2) begin errors++; $display("FAIL arst_pre: got rd=%0d wr=%0d expected 3 2", rd_cnt, wr_cnt); end
        isolate = 1'b1;
        tick();
        slv_req.aw_valid = 1'b1;
        #1;
        checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL arst_drain_block: got %b expected 0", mst_req.aw_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_cnt !== 2'd0 || wr_cnt !== 2'd0) begin errors++; $display("FAIL arst_counts: got rd=%0d wr=%0d expected 0 0", rd_cnt, wr_cnt); end
        checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL arst_run: got %b expected 1", mst_req.aw_valid); end
        slv_req.aw_valid = 1'b0;
        isolate = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        int  wr_model = 0;
        int  rd_model = 0;
        int  r_q[$];
        int  beat = 0;
        int  ntx = 0;
        bit  aw_pend = 0, ar_pend = 0, aw_stall = 0, ar_stall = 0;
        bit  aw_hs, ar_hs, b_hs, r_hs, r_last, drain;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drain = (cyc >= 560);
            if (!aw_pend) begin
                slv_req.aw_valid = !drain && ($urandom_range(0, 1) == 1);
                slv_req.aw.id = 4'($urandom_range(0, 15));
                slv_req.aw.addr = $urandom;
            end
            if (!ar_pend) begin
                slv_req.ar_valid = !drain && ($urandom_range(0, 1) == 1);
                slv_req.ar.id = 4'($urandom_range(0, 15));
                slv_req.ar.len = 8'($urandom_range(0, 3));
            end
            mst_resp.aw_ready = drain || ($urandom_range(0, 1) == 1);
            mst_resp.ar_ready = drain || ($urandom_range(0, 1) == 1);
            mst_resp.b_valid = (wr_model > 0) && (drain || ($urandom_range(0, 1) == 1));
            mst_resp.b.id = 4'($urandom_range(0, 15));
            slv_req.b_ready = drain || ($urandom_range(0, 1) == 1);
            r_last = 1'b0;
            if (r_q.size() > 0) r_last = (beat == r_q[0]);
            mst_resp.r_valid = (r_q.size() > 0) && (drain || ($urandom_range(0, 1) == 1));
            mst_resp.r.last = r_last;
            mst_resp.r.data = $urandom;
            slv_req.r_ready = drain || ($urandom_range(0, 1) == 1);
            #1;
            aw_hs = mst_req.aw_valid && mst_resp.aw_ready;
            ar_hs = mst_req.ar_valid && mst_resp.ar_ready;
            b_hs = mst_resp.b_valid && slv_req.b_ready;
            r_hs = mst_resp.r_valid && slv_req.r_ready;
            checks++; if (int'(wr_cnt) !== wr_model || int'(wr_cnt) > MaxWr) begin errors++; $display("FAIL rnd_wr_cnt cyc %0d: got %0d expected %0d", cyc, wr_cnt, wr_model); end
            checks++; if (int'(rd_cnt) !== rd_model || int'(rd_cnt) > MaxRd) begin errors++; $display("FAIL rnd_rd_cnt cyc %0d: got %0d expected %0d", cyc, rd_cnt, rd_model); end
            checks++; if ((slv_req.aw_valid && slv_resp.aw_ready) !== aw_hs || (slv_req.ar_valid && slv_resp.ar_ready) !== ar_hs) begin errors++; $display("FAIL rnd_hs_match cyc %0d: got up_aw=%b up_ar=%b expected %b %b", cyc, slv_resp.aw_ready, slv_resp.ar_ready, aw_hs, ar_hs); end
            checks++; if (slv_resp.r !== mst_resp.r || slv_resp.r_valid !== mst_resp.r_valid || slv_resp.b !== mst_resp.b) begin errors++; $display("FAIL rnd_resp_pass cyc %0d: got r=%h expected %h", cyc, slv_resp.r.data, mst_resp.r.data); end
            if (aw_stall) begin
                checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL rnd_aw_stable cyc %0d: got %b expected 1", cyc, mst_req.aw_valid); end
            end
            if (ar_stall) begin
                checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL rnd_ar_stable cyc %0d: got %b expected 1", cyc, mst_req.ar_valid); end
            end
            if (aw_hs) begin
                ntx++;
                $display("txn %0d: aw id=%0d wr_cnt=%0d", ntx, slv_req.aw.id, wr_cnt);
            end
            if (ar_hs) begin
                ntx++;
                r_q.push_back(int'(slv_req.ar.len));
                $display("txn %0d: ar id=%0d len=%0d rd_cnt=%0d", ntx, slv_req.ar.id, slv_req.ar.len, rd_cnt);
            end
            wr_model = wr_model + (aw_hs ? 1 : 0) - (b_hs ? 1 : 0);
            rd_model = rd_model + (ar_hs ? 1 : 0) - ((r_hs && r_last) ? 1 : 0);
            if (r_hs) begin
                if (r_last) begin
                    void'(r_q.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            aw_pend = slv_req.aw_valid && !slv_resp.aw_ready;
            ar_pend = slv_req.ar_valid && !slv_resp.ar_ready;
            aw_stall = mst_req.aw_valid && !mst_resp.aw_ready;
            ar_stall = mst_req.ar_valid && !mst_resp.ar_ready;
            tick();
        end
        slv_req = '0;
        mst_resp = '0;
        #1;
        checks++; if (rd_cnt !== 2'd0 || wr_cnt !== 2'd0) begin errors++; $display("FAIL rnd_final: got rd=%0d wr=%0d expected 0 0", rd_cnt, wr_cnt); end
        $display("test_random done: %0d transactions", ntx);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_aw_limit();
        test_ar_simul();
        test_isolate_aw();
        test_isolate_reads();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_txn_limiter.md
AXI_TXN_LIMITER -- requirements
Module: axi_txn_limiter

Interface
REQ-001 SHALL have parameter MaxReadTxns, default 8: max outstanding AR transactions, >= 1.
REQ-002 SHALL have parameter MaxWriteTxns, default 8: max outstanding AW transactions, >= 1.
REQ-003 SHALL have type parameters req_t and resp_t, default logic: full AXI4 request/response structs.
REQ-004 SHALL have port clk_i  input  1  sole clock.
REQ-005 SHALL have port rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port isolate_i  input  1  request to stop issuing new AW/AR and drain.
REQ-007 SHALL have port isolated_o  output  1  high when isolated and no transactions outstanding.
REQ-008 SHALL have port slv_req_i  input  req_t  upstream request (from CDC destination side).
REQ-009 SHALL have port slv_resp_o  output  resp_t  upstream response.
REQ-010 SHALL have port mst_req_o  output  req_t  downstream request.
REQ-011 SHALL have port mst_resp_i  input  resp_t  downstream response.
REQ-012 SHALL have ports rd_cnt_o / wr_cnt_o  output  $clog2(Max*Txns+1)  current outstanding counts.

Function
REQ-013 SHALL pass W, B and R channels combinationally, unmodified, zero latency.
REQ-014 SHALL pass AW payload unmodified; mst aw_valid = slv aw_valid AND aw_allow; slv aw_ready = mst aw_ready AND aw_allow.
REQ-015 SHALL compute aw_allow = aw_lock_q OR (state==RUN AND wr_cnt_q < MaxWriteTxns); AR identical with rd_cnt_q/MaxReadTxns/ar_lock_q.
REQ-016 SHALL set aw_lock_q when mst aw_valid high and aw_ready low; clear on handshake; forwarded valid never drops before handshake (AXI stability), even if isolate_i rises or count changes.
REQ-017 SHALL increment wr_cnt on downstream AW handshake, decrement on B handshake; both same cycle -> unchanged.
REQ-018 SHALL increment rd_cnt on downstream AR handshake, decrement on R handshake with r.last; both same cycle -> unchanged.
REQ-019 SHALL never exceed Max*Txns: at count==Max with no same-cycle decrement, new AW/AR not forwarded (no combinational ready->valid path from B/R).
REQ-020 SHALL implement FSM RUN, DRAIN, ISOLATED; RUN->DRAIN when isolate_i high; DRAIN->ISOLATED when both counts 0 and no lock set; DRAIN or ISOLATED->RUN when isolate_i low.
REQ-021 SHALL drive isolated_o = (state==ISOLATED), registered.
REQ-022 SHALL keep accepting W, B, R in DRAIN/ISOLATED so outstanding transactions complete.
REQ-023 SHALL flag decrement at count 0 via simulation assertion (protocol error); counter saturates at 0.

Reset
REQ-024 SHALL reset asynchronously: state=RUN, rd_cnt=0, wr_cnt=0, locks=0, isolated_o=0.
REQ-025 SHALL, on reset mid-operation, discard all counts; environment resets both sides together.

Structure
REQ-026 SHALL keep state enum local; no new package needed; uses axi/typedef.svh and axi_pkg only.
REQ-027 SHALL instantiate one sub-module axi_txn_counter twice (read, write): counter with inc/dec/max/lock logic.

Verification
REQ-028 SHALL verify MaxWriteTxns=2, 3 AWs with slave withholding B -> third AW stalls, wr_cnt_o=2; one B -> third AW forwarded next cycle.
REQ-029 SHALL verify AR handshake and R last handshake same cycle at rd_cnt=MaxReadTxns -> count unchanged, new AR not forwarded.
REQ-030 SHALL verify isolate_i rises while AW valid and not ready -> aw_valid held until handshake, then no new AW; isolated_o=1 after last B.
REQ-031 SHALL verify isolate_i with 3 reads outstanding (4-beat bursts) -> all 12 R beats delivered, isolated_o=1 one cycle after count 0.
REQ-032 SHALL verify rst_ni low mid-burst with 5 outstanding -> counts 0 and state RUN immediately, without clock.
REQ-033 SHALL verify rand_axi_master/rand_axi_slave, 1000 txns, Max=4 -> all responses match, counts never exceed 4, final counts 0.
